// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider defines: state encodings, cycle count, divide-by-zero fill
package div_unit_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // LO on divide-by-zero is this bit replicated across the quotient width
  localparam logic DIV_ZERO_LO_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration on {rem, quo}
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  // shifted rem can exceed WIDTH bits for large unsigned divisors; the
  // kept remainder always fits because it ends up below the divisor
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rem_out = trial[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring DIV/DIVU unit with stall request and annul
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               annul,
  output logic               stall_req,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo, rem_fix, quo_fix;
  logic             unused_mag_bits;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // magnitudes at WIDTH+1 bits so the most negative operand negates cleanly
  assign a_neg = signed_div & opa[WIDTH-1];
  assign b_neg = signed_div & opb[WIDTH-1];
  assign a_ext = {a_neg, opa};
  assign b_ext = {b_neg, opb};
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;
  assign unused_mag_bits = a_mag[WIDTH] ^ b_mag[WIDTH];

  assign quo_fix = qneg_q ? -step_quo : step_quo;
  assign rem_fix = rneg_q ? -step_rem : step_rem;

  assign ready     = (state_q == DIV_DONE);
  assign stall_req = start & ~ready & ~annul;
  assign result    = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      DIV_IDLE: begin
        if (start && !annul) begin
          if (opb != '0) begin
            rem_d   = '0;
            quo_d   = a_mag[WIDTH-1:0];
            dvs_d   = b_mag[WIDTH-1:0];
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = '0;
            state_d = DIV_RUN;
          end else begin
            result_d = {opa, {WIDTH{DIV_ZERO_LO_BIT}}};
            state_d  = DIV_DONE;
          end
        end
      end
      DIV_RUN: begin
        if (annul) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_CNT) begin
            result_d = {rem_fix, quo_fix};
            state_d  = DIV_DONE;
          end
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vector bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa, opb;
  logic        annul;
  logic        stall_req;
  logic        ready;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .annul      (annul),
    .stall_req  (stall_req),
    .ready      (ready),
    .result     (result)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
    int          mut_cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one divide starting next negedge (cycle 0) and runs until ready or budget
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int mut_cyc, output int lat, output logic [63:0] res,
                        output int stall_bad);
    @(negedge clk);
    start = 1'b1; signed_div = s; opa = a; opb = b;
    lat = -1; res = '0; stall_bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (c == mut_cyc) begin
        opa = ~a; opb = 32'h1234_5678; signed_div = ~s;
      end
      #1;
      if (ready) begin
        lat = c; res = result;
        if (stall_req) stall_bad++;
        break;
      end
      if (!stall_req) stall_bad++;
      @(negedge clk);
    end
  endtask

  int          lat, stall_bad;
  logic [63:0] res;
  logic        seen;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'h0000000E, 32'h00000002, 33, -1};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFD, 32'hFFFFFFFF, 33, -1};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFF, 32'h00000000, 33, -1};
    vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000, 33, -1};
    vecs[4]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000, 33, -1};
    vecs[5]  = '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF, 32'h00000005, 1,  -1};
    vecs[6]  = '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF, 32'h00000005, 1,  -1};
    vecs[7]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001, 33, -1};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'h0000000E, 32'hFFFFFFFE, 33, -1};
    vecs[9]  = '{1'b0, 32'd0,         32'd5,         32'h00000000, 32'h00000000, 33, -1};
    vecs[10] = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF, 32'hFFFFFFFB, 1,  -1};
    vecs[11] = '{1'b0, 32'd1000,      32'd10,        32'd100,      32'd0,        33, 5};

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_stall_idle", 64'(stall_req), 64'd0);
    start = 1'b1; #1;
    chk("reset_stall_unmasked", 64'(stall_req), 64'd1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // back-to-back: start stays high, each divide issued the cycle after DONE
    foreach (vecs[i]) begin
      do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].mut_cyc, lat, res, stall_bad);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), res, {vecs[i].hi, vecs[i].lo});
      chk($sformatf("v%0d_stall", i), 64'(stall_bad), 64'd0);
    end

    // annul in cycle 10 of a run
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (10) @(negedge clk);
    annul = 1'b1; #1;
    chk("annul_stall_low", 64'(stall_req), 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      #1; if (ready) seen = 1'b1;
      @(negedge clk);
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, -1, lat, res, stall_bad);
    chk("annul_next_latency", 64'(lat), 64'd33);
    chk("annul_next_result", res, {32'd0, 32'd3});

    // reset in cycle 20 of a run
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("midrun_reset_ready", 64'(ready), 64'd0);
    chk("midrun_reset_result", result, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      #1; if (ready) seen = 1'b1;
      @(negedge clk);
    end
    chk("midrun_reset_no_ready", 64'(seen), 64'd0);
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, -1, lat, res, stall_bad);
    chk("post_reset_latency", 64'(lat), 64'd33);
    chk("post_reset_result", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    @(negedge clk);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage, serving DIV/DIVU and writing HI/LO.
- It is the requester side of the pipeline stall interface: it raises stall_req toward the hazard logic, and accepts annul when the hazard/exception logic flushes EX.
- It produces {remainder, quotient}, which the pipeline carries toward the HI/LO write in M/W.

Parameters:
- WIDTH, 32, operand width in bits; the quotient and the remainder are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  a DIV/DIVU instruction is in EX; held high while the stage is stalled.
- signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opa  input  WIDTH  dividend (rs).
- opb  input  WIDTH  divisor (rt).
- annul  input  1  flush of EX; abandons the operation in flight.
- stall_req  output  1  to the hazard logic; holds F/D/E while the divide is incomplete.
- ready  output  1  one-cycle pulse: result is valid this cycle.
- result  output  2*WIDTH  {hi = remainder, lo = quotient}.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is shared (see Decomposition). Counter cnt is 6 bits.
- Reset (rst=1 at a clock edge, in any state, including mid-RUN):
  - state goes to IDLE, cnt=0, ready=0, result=0.
  - stall_req is then combinational on start; rst does not mask it.
- IDLE:
  - start=1, annul=0, opb!=0: latch operand magnitudes, the quotient sign (sign(a) xor sign(b), signed only) and the remainder sign (sign(a), signed only); cnt=0; go to RUN.
  - start=1, annul=0, opb==0: latch result = {opa, all-ones}; go to DONE.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle: shift {rem,quo} left by 1, trial-subtract |b| from rem; if non-negative, keep the difference and set the quotient LSB.
  - After the WIDTH-th iteration (cnt==WIDTH-1), apply the sign fix-ups (two's-complement negate where flagged), register result, and go to DONE.
- DONE:
  - ready=1 for exactly this cycle; go to IDLE unconditionally.
  - A back-to-back divide in the next instruction starts from IDLE on the following cycle.
- Latency:
  - Start accepted in cycle 0 → ready in cycle WIDTH+1 (33 for the default).
  - Divide by zero → ready in cycle 1.
- stall_req = start & ~ready & ~annul (combinational).
  - It is high from cycle 0 through cycle WIDTH.
  - It is low in the DONE cycle, so EX advances while result is valid.
- Operand inputs are ignored after acceptance; changes during RUN have no effect.
- result holds its value after DONE until the next completion or reset. It is meaningful only while ready=1.
- annul:
  - Any state: next state is IDLE; ready is not asserted for the annulled operation.
  - annul in the DONE cycle: ready is still 1 that cycle; the consumer discards it.
  - annul together with start in IDLE: the start is not accepted.
- Arithmetic rules:
  - Signed ops use magnitudes computed at WIDTH+1 bits, so |-2^31| is representable.
  - 0x80000000 / 0xFFFFFFFF (signed) → quotient 0x80000000, remainder 0; no trap.
  - Unsigned divide-by-zero result follows the same rule: hi=opa, lo=all-ones.

Decomposition:
- Shared package (pipeline defines): state encodings DIV_IDLE/DIV_RUN/DIV_DONE, DIV_CYCLES=WIDTH, and the divide-by-zero LO constant.
- One natural sub-module, div_step: combinational single iteration taking {rem,quo} and the divisor, returning the next {rem,quo}.
- The FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- Unsigned 100/7, start held → stall_req high cycles 0..32; ready only in cycle 33; result={0x00000002, 0x0000000E}.
- Signed -7/2 (0xFFFFFFF9/0x00000002) → ready cycle 33; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then unsigned 0xFFFFFFFF/1 issued in cycle 34 → lo=0xFFFFFFFF, hi=0, ready cycle 67.
- Signed 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. Unsigned 0x80000000/0xFFFFFFFF → lo=0, hi=0x80000000.
- 5/0 (either signedness) → ready in cycle 1; result={0x00000005, 0xFFFFFFFF}; stall_req high only in cycle 0.
- Annul: annul pulsed in cycle 10 of a run → IDLE in cycle 11, no ready pulse; a new 9/3 started afterwards → lo=3, hi=0 after 33 cycles.
- Reset: rst asserted in cycle 20 of a run → next cycle state IDLE, result=0, ready=0; operand changes during RUN do not alter the result.
